// File: rtl/pwm_capture.sv
// PWM receiver: measures the high time and period of pwm_in and reports the
// duty cycle as an integer percent, using a serial restoring divider.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [6:0]       duty_cycle,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             busy,
  output logic             stuck
);

  localparam int DIV_W = CNT_W + 7;
  localparam int DC_W  = $clog2(DIV_W) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [DIV_W-1:0] HUNDRED     = DIV_W'(100);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic [CNT_W-1:0]       per_cnt;
  logic [CNT_W-1:0]       hi_cnt;
  logic [CNT_W-1:0]       idle_cnt;
  logic [DIV_W-1:0]       num_q;
  logic [CNT_W-1:0]       den_q;
  logic [CNT_W-1:0]       rem_q;
  logic [DC_W-1:0]        div_cnt;

  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   timeout_run;
  logic                   timeout_idle;
  logic                   complete;
  logic                   div_last;
  logic [CNT_W:0]         rem_shift;
  logic [CNT_W:0]         rem_sub;
  logic                   quo_bit;
  logic [CNT_W-1:0]       rem_next;
  logic [DIV_W-1:0]       quo_next;
  logic [6:0]             duty_clamped;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign timeout_run  = (state != IDLE) && (per_cnt == TIMEOUT_VAL) && !rise;
  assign timeout_idle = (state == IDLE) && !stuck && (idle_cnt == TIMEOUT_VAL) && !rise;
  assign complete     = (state == LOW) && rise;
  assign div_last     = busy && (div_cnt == DC_W'(DIV_W - 1));

  // Since rem < den, the shifted remainder is below 2*den, so the top bit of
  // the wrapped difference doubles as the borrow: clear means rem_shift >= den.
  assign rem_shift    = {rem_q, num_q[DIV_W-1]};
  assign rem_sub      = rem_shift - {1'b0, den_q};
  assign quo_bit      = ~rem_sub[CNT_W];
  assign rem_next     = quo_bit ? rem_sub[CNT_W-1:0] : rem_shift[CNT_W-1:0];
  assign quo_next     = {num_q[DIV_W-2:0], quo_bit};
  assign duty_clamped = (quo_next > HUNDRED) ? 7'd100 : quo_next[6:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      s_d        <= 1'b0;
      state      <= IDLE;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      idle_cnt   <= '0;
      num_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      div_cnt    <= '0;
      duty_cycle <= '0;
      period     <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
      valid  <= 1'b0;

      // Measurement FSM; the cycle carrying the completing rise already
      // counts as cycle 1 of the next period, so there is no dead cycle.
      case (state)
        IDLE: begin
          per_cnt <= '0;
          hi_cnt  <= '0;
          if (rise) begin
            state    <= HIGH;
            per_cnt  <= CNT_W'(1);
            hi_cnt   <= CNT_W'(1);
            idle_cnt <= '0;
          end else if (timeout_idle) begin
            idle_cnt <= '0;
          end else if (!stuck) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        HIGH: begin
          idle_cnt <= '0;
          if (timeout_run) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end else begin
            per_cnt <= per_cnt + 1'b1;
            if (fall) state <= LOW;
            else      hi_cnt <= hi_cnt + 1'b1;
          end
        end
        LOW: begin
          idle_cnt <= '0;
          if (rise) begin
            state   <= HIGH;
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
          end else if (timeout_run) begin
            state   <= IDLE;
            per_cnt <= '0;
            hi_cnt  <= '0;
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          per_cnt  <= '0;
          hi_cnt   <= '0;
          idle_cnt <= '0;
        end
      endcase

      // A timeout overrides any division in flight; otherwise samples are
      // only taken while the divider is free.
      if (timeout_run || timeout_idle) begin
        duty_cycle <= s ? 7'd100 : 7'd0;
        period     <= '0;
        stuck      <= 1'b1;
        valid      <= 1'b1;
        busy       <= 1'b0;
      end else if (busy) begin
        num_q   <= quo_next;
        rem_q   <= rem_next;
        div_cnt <= div_cnt + 1'b1;
        if (div_last) begin
          duty_cycle <= duty_clamped;
          period     <= den_q;
          valid      <= 1'b1;
          busy       <= 1'b0;
          stuck      <= 1'b0;
        end
      end else if (complete) begin
        num_q   <= DIV_W'(hi_cnt) * HUNDRED;
        den_q   <= per_cnt;
        rem_q   <= '0;
        div_cnt <= '0;
        busy    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus tasks push expected reports,
// an independent monitor pops and compares them whenever valid pulses.
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 600;
  localparam int SYNC_STAGES = 3;
  localparam int DIV_W       = CNT_W + 7;

  typedef struct {
    int duty;
    int per;
    int stk;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [6:0]       duty_cycle;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             busy;
  logic             stuck;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   errors    = 0;
  int   cyc       = 0;
  int   busy_len  = 0;
  int   free_at   = 0;
  int   have_prev = 0;
  int   prev_duty = 0;
  int   prev_per  = 0;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty_cycle(duty_cycle),
    .period    (period),
    .valid     (valid),
    .busy      (busy),
    .stuck     (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // A rise completes the previous period; it is reported only if the
  // divider has finished the last accepted sample (DIV_W+1 cycles later).
  task automatic noteRise(input int per, input int duty);
    if (have_prev != 0 && cyc >= free_at) begin
      exp_q.push_back('{duty: prev_duty, per: prev_per, stk: 0});
      free_at = cyc + DIV_W + 1;
    end
    prev_duty = duty;
    prev_per  = per;
    have_prev = 1;
  endtask

  task automatic applyStimulus(input int hi, input int lo, input int n, input int exp_duty);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      noteRise(hi + lo, exp_duty);
      repeat (hi) stepCycle();
      pwm_in = 1'b0;
      repeat (lo) stepCycle();
    end
  endtask

  task automatic holdLevel(input logic lvl, input int n, input int exp_duty);
    if (lvl && !pwm_in) noteRise(0, 0);
    pwm_in = lvl;
    exp_q.push_back('{duty: exp_duty, per: 0, stk: 1});
    have_prev = 0;
    repeat (n) stepCycle();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_duty"},   int'(duty_cycle), 0);
    checkOutput({tag, "_period"}, int'(period), 0);
    checkOutput({tag, "_valid"},  int'(valid), 0);
    checkOutput({tag, "_busy"},   int'(busy), 0);
    checkOutput({tag, "_stuck"},  int'(stuck), 0);
  endtask

  // Monitor: every valid must match the oldest expectation; a normal
  // measurement must follow exactly DIV_W busy cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid actual=1 required=0 (duty=%0d period=%0d)",
                   duty_cycle, period);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("duty", int'(duty_cycle), mon_e.duty);
          checkOutput("period", int'(period), mon_e.per);
          checkOutput("stuck", int'(stuck), mon_e.stk);
          if (mon_e.stk == 0) checkOutput("busy_len", busy_len, DIV_W);
        end
      end
      busy_len = busy ? busy_len + 1 : 0;
    end else begin
      busy_len = 0;
    end
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) stepCycle();
    checkAllZero("reset");
    rst = 1'b0;
    stepCycle();

    $display("[TB] 50/50 for 5 periods");
    applyStimulus(50, 50, 5, 50);

    $display("[TB] 50/150, then 1/2 with samples dropped while busy");
    applyStimulus(50, 150, 3, 25);
    applyStimulus(1, 2, 20, 33);

    $display("[TB] stuck low after 50 percent, then recovery with 30/70");
    applyStimulus(50, 50, 3, 50);
    holdLevel(1'b0, TIMEOUT + 10, 0);
    applyStimulus(30, 70, 3, 30);

    $display("[TB] stuck high");
    holdLevel(1'b1, TIMEOUT + 10, 100);

    $display("[TB] reset during division");
    pwm_in = 1'b0;
    repeat (5) stepCycle();
    applyStimulus(40, 60, 2, 40);
    pwm_in = 1'b1;
    noteRise(100, 40);
    for (int i = 0; i < 20 && !busy; i++) stepCycle();
    checkOutput("busy_before_reset", int'(busy), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    pwm_in = 1'b0;
    rst    = 1'b1;
    stepCycle();
    rst       = 1'b0;
    have_prev = 0;
    free_at   = 0;
    checkAllZero("after_reset");
    applyStimulus(20, 80, 3, 20);

    $display("[TB] generator loopback, duty 50 then 0");
    applyStimulus(40, 40, 4, 50);
    holdLevel(1'b0, TIMEOUT + 10, 0);

    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) stepCycle();
    checkOutput("pending_expectations", exp_q.size(), 0);
    repeat (5) stepCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
